// File: rtl/nor_timing_checker.sv
// rtl/nor_timing_checker.sv - inertial-delay model of a masked 4-input NOR with output checking
module nor_timing_checker #(
  parameter int DELAY_CYC = 9,
  parameter bit IV        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  a,
  input  logic [3:0]  mask,
  input  logic        y,
  input  logic        clr,
  output logic        expected,
  output logic        busy,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [15:0] err_count
);

  typedef enum logic {SETTLED = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [7:0] LAST = 8'(DELAY_CYC - 1);
  localparam logic [1:0] CODE_EARLY    = 2'b01;
  localparam logic [1:0] CODE_MISMATCH = 2'b10;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       expected_nx;
  logic       target;
  logic       mis, mis_q, start;
  logic [1:0] cls;

  assign target = ~|(a & mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SETTLED;
      cnt      <= 8'd0;
      expected <= IV;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      expected <= expected_nx;
    end
  end

  // A target that returns to the modelled value before the delay elapses is swallowed.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    expected_nx = expected;
    case (state)
      SETTLED: begin
        if (target != expected) begin
          state_nx = PENDING;
          cnt_nx   = 8'd0;
        end
      end
      PENDING: begin
        if (target == expected) begin
          state_nx = SETTLED;
        end else if (cnt == LAST) begin
          expected_nx = target;
          state_nx    = SETTLED;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = SETTLED;
    endcase
  end

  always_comb begin
    busy = (state == PENDING);
  end

  assign mis   = en & (y != expected);
  assign start = mis & ~mis_q;
  assign cls   = (state == PENDING && y == target) ? CODE_EARLY : CODE_MISMATCH;

  // An episode is a run of consecutive mismatch cycles; only its first cycle is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q     <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
      err_count <= 16'd0;
    end else begin
      mis_q     <= mis;
      err_pulse <= start;
      if (clr) begin
        err_code  <= start ? cls : 2'b00;
        err_count <= start ? 16'd1 : 16'd0;
      end else if (start) begin
        err_code <= cls;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
